// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO into a first-word-fall-through valid/ready stream with a 2-entry skid buffer
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
  logic [1:0] occ;
  logic pend, pop, push;
  logic [2:0] occ_nxt;
  logic [DATA_WIDTH-1:0] skid;
  assign pop = m_valid && m_ready;
  assign push = pend;
  assign occ_nxt = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
  // occ_nxt counts the word in flight, so a read is only issued when it is guaranteed a slot
  assign rd_en = !rd_rst && !empty && occ_nxt < 3'd2;
  assign m_valid = occ != EMPTY;
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      occ <= EMPTY;
      pend <= 1'b0;
      word_cnt <= '0;
    end else begin
      assert (!(push && occ == TWO));
      occ <= occ_nxt[1:0];
      pend <= rd_en;
      if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
      if (pop && occ == TWO) m_data <= skid;
      else if (push && (occ == EMPTY || pop)) m_data <= rd_data;
      if (push && occ == ONE && !pop) skid <= rd_data;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a queue model of the FIFO and a scoreboard
module tb_fifo_rd_stream;
  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;
  logic rd_rst = 1'b1, empty = 1'b1, m_ready = 1'b0, gate = 1'b0;
  logic rd_en, m_valid;
  logic [7:0] rd_data = 8'hEE, m_data;
  logic [3:0] word_cnt;
  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .empty(empty), .rd_en(rd_en), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .word_cnt(word_cnt)
  );
  int checks = 0, failures = 0, viol = 0;
  logic [7:0] fq[$], exp_q[$];
  logic [7:0] t1w [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic s_en, s_valid, s_pop, hold = 1'b0;
  logic [7:0] s_data, hold_data;
  logic [3:0] s_cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  task automatic load(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask
  // one rd_clk cycle: settle inputs, sample, scoreboard, edge, then model the FIFO's registered read port
  task automatic step();
    empty = (fq.size() == 0) || gate;
    #1;
    s_en = rd_en;
    s_valid = m_valid;
    s_data = m_data;
    s_cnt = word_cnt;
    s_pop = m_valid && m_ready;
    if (rd_en && empty) viol++;
    if (hold) begin
      chk("hold_valid", s_valid, 1);
      chk("hold_data", s_data, hold_data);
    end
    hold = s_valid && !m_ready && !rd_rst;
    hold_data = s_data;
    if (s_pop && !rd_rst) begin
      if (exp_q.size() == 0) chk("sb_extra", 1, 0);
      else chk("sb_data", s_data, exp_q.pop_front());
    end
    @(posedge rd_clk);
    #1;
    rd_data = (s_en && fq.size() != 0) ? fq.pop_front() : 8'hEE;
  endtask
  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask
  initial begin
    int pulses, pops, n, loaded;
    load(8'hA1); load(8'hB2); load(8'hC3);
    m_ready = 1'b1;
    step();
    chk("rst_rd_en", s_en, 0);
    step();
    chk("rst_valid", s_valid, 0);
    chk("rst_cnt", s_cnt, 0);
    rd_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t1_rd_en", s_en, c <= 2);
      chk("t1_valid", s_valid, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) chk("t1_data", s_data, t1w[c-2]);
      if (c == 5) chk("t1_cnt", s_cnt, 3);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(8'h10 + 8'(i));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses += int'(s_en);
    end
    chk("t2_pulses", pulses, 2);
    chk("t2_valid", s_valid, 1);
    chk("t2_first", s_data, 8'h10);
    m_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pops += int'(s_pop);
    end
    chk("t2_nogap", pops, 5);
    chk("t2_left", exp_q.size(), 0);
    step();
    chk("t2_cnt", s_cnt, 8);
    for (int i = 0; i < 10; i++) load(8'h20 + 8'(i));
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      gate = n[0];
      step();
      n++;
    end
    chk("t3_drain", exp_q.size(), 0);
    gate = 1'b0;
    step();
    step();
    chk("t3_viol", viol, 0);
    chk("t3_cnt", s_cnt, 2);
    m_ready = 1'b0;
    load(8'h31);
    step(); step(); step();
    load(8'h32);
    step();
    chk("t4_rd_en", s_en, 1);
    m_ready = 1'b1;
    step();
    chk("t4_pop_data", s_data, 8'h31);
    m_ready = 1'b0;
    step();
    chk("t4_valid", s_valid, 1);
    chk("t4_data", s_data, 8'h32);
    m_ready = 1'b1;
    step();
    step();
    chk("t4_one_left", s_valid, 0);
    chk("t4_cnt", s_cnt, 4);
    m_ready = 1'b0;
    load(8'h41); load(8'h42); load(8'h43);
    step(); step();
    rd_rst = 1'b1;
    step();
    chk("t5_pre_valid", s_valid, 1);
    fq.delete();
    exp_q.delete();
    rd_rst = 1'b0;
    step();
    chk("t5_valid", s_valid, 0);
    chk("t5_cnt", s_cnt, 0);
    load(8'h51);
    m_ready = 1'b1;
    drain("t5_drain", 10);
    step();
    chk("t5_cnt2", s_cnt, 1);
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    for (int i = 0; i < 17; i++) load(8'h60 + 8'(i));
    drain("t6_wrap_drain", 40);
    step();
    chk("t6_wrap", s_cnt, 1);
    loaded = 0;
    n = 0;
    while ((loaded < 40 || n < 100) && n < 400) begin
      if (loaded < 40 && $urandom_range(0, 2) == 0) begin
        load(8'($urandom_range(0, 8'hED)));
        loaded++;
      end
      m_ready = 1'($urandom_range(0, 1));
      gate = $urandom_range(0, 3) == 0;
      step();
      n++;
    end
    chk("t6_loaded", loaded, 40);
    gate = 1'b0;
    m_ready = 1'b1;
    drain("t6_drain", 100);
    step();
    chk("t6_cnt", s_cnt, 9);
    chk("t6_viol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
